// File: rtl/bcd_countdown_timer.sv
`default_nettype none
// ============================================================================
// Module      : bcd_countdown_timer
// Description : Packed-BCD hh:mm:ss countdown timer. It is loaded with a
//               duration of up to 23:59:59 and decrements by one second on
//               each tick strobe. Expiry is flagged by a one-cycle done pulse.
//               Optional macro TIMER_AUTORELOAD_EN reloads the last valid
//               load value on expiry instead of entering EXPIRED.
// Revision    : 1.0 - initial release
// ============================================================================
module bcd_countdown_timer (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick,
  input  logic       load,
  input  logic [7:0] load_hh,
  input  logic [7:0] load_mm,
  input  logic [7:0] load_ss,
  input  logic       start,
  input  logic       stop,
  output logic [7:0] hh,
  output logic [7:0] mm,
  output logic [7:0] ss,
  output logic       running,
  output logic       expired,
  output logic       done,
  output logic       err
);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_RUN     = 2'd1;
  localparam logic [1:0] S_EXPIRED = 2'd2;

  logic [1:0] r_state;
  logic [7:0] r_hh;
  logic [7:0] r_mm;
  logic [7:0] r_ss;
  logic       r_done;
  logic       r_err;

  logic [7:0] w_dec_hh;
  logic [7:0] w_dec_mm;
  logic [7:0] w_dec_ss;
  logic       w_ss_borrow;
  logic       w_mm_borrow;
  logic       w_dec_zero;
  logic       w_nonzero;
  logic       w_load_ok;

  // Decrement a 00-59 BCD field, wrapping 00 to 59 (borrow handled by caller)
  function automatic logic [7:0] dec_bcd60(input logic [7:0] v);
    if (v[3:0] != 4'd0)
      dec_bcd60 = {v[7:4], v[3:0] - 4'd1};
    else if (v[7:4] != 4'd0)
      dec_bcd60 = {v[7:4] - 4'd1, 4'd9};
    else
      dec_bcd60 = 8'h59;
  endfunction

  // Candidate value one second lower; hours never underflow because the
  // zero result is detected before any further tick is accepted
  always_comb begin
    w_ss_borrow = (r_ss == 8'h00);
    w_mm_borrow = w_ss_borrow && (r_mm == 8'h00);
    w_dec_ss    = dec_bcd60(r_ss);
    w_dec_mm    = w_ss_borrow ? dec_bcd60(r_mm) : r_mm;
    w_dec_hh    = r_hh;
    if (w_mm_borrow) begin
      if (r_hh[3:0] != 4'd0)
        w_dec_hh = {r_hh[7:4], r_hh[3:0] - 4'd1};
      else
        w_dec_hh = {r_hh[7:4] - 4'd1, 4'd9};
    end
    w_dec_zero = ({w_dec_hh, w_dec_mm, w_dec_ss} == 24'h000000);
    w_nonzero  = ({r_hh, r_mm, r_ss} != 24'h000000);
  end

  // Load is accepted only when every field is legal packed BCD in range
  always_comb begin
    w_load_ok = (load_hh[3:0] <= 4'd9) && (load_hh <= 8'h23) &&
                (load_mm[3:0] <= 4'd9) && (load_mm[7:4] <= 4'd5) &&
                (load_ss[3:0] <= 4'd9) && (load_ss[7:4] <= 4'd5);
  end

`ifdef TIMER_AUTORELOAD_EN
  logic [7:0] r_pre_hh;
  logic [7:0] r_pre_mm;
  logic [7:0] r_pre_ss;

  // Preset keeps the most recent valid load for reload on expiry
  always_ff @(posedge clk) begin
    if (reset) begin
      r_pre_hh <= 8'h00;
      r_pre_mm <= 8'h00;
      r_pre_ss <= 8'h00;
    end else if (load && w_load_ok) begin
      r_pre_hh <= load_hh;
      r_pre_mm <= load_mm;
      r_pre_ss <= load_ss;
    end
  end
`endif

  // Control: one input acts per cycle, reset > load > stop > start > tick
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_hh    <= 8'h00;
      r_mm    <= 8'h00;
      r_ss    <= 8'h00;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      r_err  <= 1'b0;
      if (load) begin
        if (w_load_ok) begin
          r_hh    <= load_hh;
          r_mm    <= load_mm;
          r_ss    <= load_ss;
          r_state <= S_IDLE;
        end else begin
          r_err <= 1'b1;
        end
      end else if (stop) begin
        if (r_state == S_RUN)
          r_state <= S_IDLE;
      end else if (start) begin
        if ((r_state == S_IDLE) && w_nonzero)
          r_state <= S_RUN;
      end else if (tick && (r_state == S_RUN)) begin
        if (w_dec_zero) begin
          r_done <= 1'b1;
`ifdef TIMER_AUTORELOAD_EN
          r_hh <= r_pre_hh;
          r_mm <= r_pre_mm;
          r_ss <= r_pre_ss;
`else
          r_hh    <= 8'h00;
          r_mm    <= 8'h00;
          r_ss    <= 8'h00;
          r_state <= S_EXPIRED;
`endif
        end else begin
          r_hh <= w_dec_hh;
          r_mm <= w_dec_mm;
          r_ss <= w_dec_ss;
        end
      end
    end
  end

  assign hh      = r_hh;
  assign mm      = r_mm;
  assign ss      = r_ss;
  assign running = (r_state == S_RUN);
  assign expired = (r_state == S_EXPIRED);
  assign done    = r_done;
  assign err     = r_err;

endmodule
`default_nettype wire
